// File: rtl/spi_ram_burst_pkg.sv
// spi_ram_pkg: opcode and TX FSM encodings shared by the SPI RAM slave
package spi_ram_pkg;
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_t;
  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_VALID = 1'b1
  } tx_state_t;
endpackage

// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: command/read-data bus between the SPI slave (master) and the RAM (slave)
interface spi_ram_burst_if #(
  parameter int DATA_W    = 8,
  parameter int PAYLOAD_W = 8
);
  logic                 rx_valid;
  logic [PAYLOAD_W+1:0] din;
  logic [DATA_W-1:0]    dout;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 err_ovf;
  logic                 err_addr;
  modport master (output rx_valid, din, tx_ready, input dout, tx_valid, err_ovf, err_addr);
  modport slave  (input rx_valid, din, tx_ready, output dout, tx_valid, err_ovf, err_addr);
endinterface

// File: rtl/spi_ram_burst_array.sv
// spi_ram_array: DATA_W x MEM_DEPTH storage, synchronous write and registered read
module spi_ram_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // rdata only moves on an accepted read, so it doubles as the held tx word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: opcode-driven RAM slave with tx handshake; SPI_RAM_AUTOINC_EN enables burst pointers
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W,
  parameter int PAYLOAD_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_burst_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH-1);
  op_t                  op;
  tx_state_t            st;
  logic [PAYLOAD_W-1:0] pl;
  logic [ADDR_W-1:0]    pa, waddr, raddr;
  logic                 a_ok, we, rd, rd_ok;
  assign op    = op_t'(bus.din[PAYLOAD_W+1:PAYLOAD_W]);
  assign pl    = bus.din[PAYLOAD_W-1:0];
  assign pa    = pl[ADDR_W-1:0];
  assign a_ok  = {1'b0, pa} < DEPTH;
  assign we    = bus.rx_valid && op == OP_WR_DATA;
  assign rd    = bus.rx_valid && op == OP_RD_DATA;
  assign rd_ok = rd && (st == TX_IDLE || bus.tx_ready);
`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st           <= TX_IDLE;
      bus.tx_valid <= 1'b0;
      bus.err_ovf  <= 1'b0;
      bus.err_addr <= 1'b0;
      waddr        <= '0;
      raddr        <= '0;
    end else begin
      if (bus.rx_valid && (op == OP_WR_ADDR || op == OP_RD_ADDR) && !a_ok) bus.err_addr <= 1'b1;
      if (bus.rx_valid && op == OP_WR_ADDR && a_ok) waddr <= pa;
      if (bus.rx_valid && op == OP_RD_ADDR && a_ok) raddr <= pa;
`ifdef SPI_RAM_AUTOINC_EN
      if (we) waddr <= inc(waddr);
      if (rd_ok) raddr <= inc(raddr);
`endif
      if (rd && !rd_ok) bus.err_ovf <= 1'b1;
      st           <= rd_ok ? TX_VALID : (bus.tx_ready ? TX_IDLE : st);
      bus.tx_valid <= rd_ok || (st == TX_VALID && !bus.tx_ready);
    end
  spi_ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (pl[DATA_W-1:0]),
    .re    (rd_ok),
    .raddr (raddr),
    .rdata (bus.dout)
  );
endmodule
